// File: rtl/mix_columns_seq_pkg.sv
// AES GF(2^8) helpers and shared types for the iterative MixColumns engine.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] column_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mixcol_state_t;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic byte_t gf_mul2(input byte_t b);
        return xtime(b);
    endfunction

    function automatic byte_t gf_mul3(input byte_t b);
        return xtime(b) ^ b;
    endfunction

    function automatic byte_t gf_mul9(input byte_t b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic byte_t gf_mulb(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic byte_t gf_muld(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic byte_t gf_mule(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/mix_columns_seq_single_column.sv
// Combinational MixColumns of one 32-bit column (byte r=0 at MSB).
// MIX_INV_EN: when defined, the inverse input selects InvMixColumns.
module mix_single_column
    import aes_pkg::*;
(
    input  column_t col_in,
    input  logic    inverse,
    output column_t col_out
);

    function automatic byte_t fwd_row(input byte_t x0, input byte_t x1,
                                      input byte_t x2, input byte_t x3);
        return gf_mul2(x0) ^ gf_mul3(x1) ^ x2 ^ x3;
    endfunction

    byte_t   a0, a1, a2, a3;
    column_t fwd_col;

    assign {a0, a1, a2, a3} = col_in;
    assign fwd_col = {fwd_row(a0, a1, a2, a3), fwd_row(a1, a2, a3, a0),
                      fwd_row(a2, a3, a0, a1), fwd_row(a3, a0, a1, a2)};

`ifdef MIX_INV_EN
    function automatic byte_t inv_row(input byte_t x0, input byte_t x1,
                                      input byte_t x2, input byte_t x3);
        return gf_mule(x0) ^ gf_mulb(x1) ^ gf_muld(x2) ^ gf_mul9(x3);
    endfunction

    column_t inv_col;
    assign inv_col = {inv_row(a0, a1, a2, a3), inv_row(a1, a2, a3, a0),
                      inv_row(a2, a3, a0, a1), inv_row(a3, a0, a1, a2)};

    // Select transform direction for this block
    always_comb begin
        col_out = inverse ? inv_col : fwd_col;
    end
`else
    logic unused_inverse;
    assign unused_inverse = inverse;

    // Forward transform only
    always_comb begin
        col_out = fwd_col;
    end
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns engine: COLS_PER_CYCLE columns per clock, valid/ready
// handshakes on both sides. MIX_INV_EN: enables per-block InvMixColumns via i_inverse.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [127:0] i_data,
    input  logic         i_valid,
    input  logic         i_inverse,
    output logic         o_ready,
    output logic [127:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Counter step and last start column; for CPC=4 both truncate to 0 in 2 bits
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

    mixcol_state_t state, state_next;
    logic [1:0]    cnt;
    column_t       work [4];
    logic          mode;
    logic          accept;

    logic [1:0]    col_idx [COLS_PER_CYCLE];
    column_t       mixed   [COLS_PER_CYCLE];

    assign accept  = (state == IDLE) && i_valid;
    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_idx[g] = cnt + 2'(g);

        mix_single_column u_col (
            .col_in  (work[col_idx[g]]),
            .inverse (mode),
            .col_out (mixed[g])
        );
    end

`ifdef MIX_INV_EN
    // Mode register: direction sampled once per block at accept
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mode <= 1'b0;
        end else if (accept) begin
            mode <= i_inverse;
        end
    end
`else
    logic unused_inverse;
    assign unused_inverse = i_inverse;
    assign mode = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_valid) state_next = BUSY;
            BUSY:    if (cnt == CNT_LAST) state_next = DONE;
            DONE:    if (i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Column counter: wraps back to 0 on the last BUSY cycle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (state == BUSY) begin
            cnt <= cnt + CNT_STEP;
        end
    end

    // Work register: load on accept, in-place column write-back while BUSY
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned c = 0; c < 4; c++) work[c] <= '0;
        end else if (accept) begin
            for (int unsigned c = 0; c < 4; c++) work[c] <= i_data[127 - 32*c -: 32];
        end else if (state == BUSY) begin
            for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) work[col_idx[g]] <= mixed[g];
        end
    end

    // Output state is the work register, column 0 at the MSB
    always_comb begin
        o_data = '0;
        for (int unsigned c = 0; c < 4; c++) o_data[127 - 32*c -: 32] = work[c];
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: known-answer vectors, latency,
// backpressure, mid-block reset and a randomized stream against a GF(2^8) model.
module tb_mix_columns_seq;

    parameter int unsigned COLS_PER_CYCLE = 1;
    localparam int unsigned N = 4 / COLS_PER_CYCLE;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] COLV_IN  = 128'hdb135345_f20a225c_c6c6c6c6_2d26314c;
    localparam logic [127:0] COLV_OUT = 128'h8e4da1bc_9fdc589d_c6c6c6c6_4d7ebdf8;

    logic         clk;
    logic         n_rst;
    logic [127:0] i_data;
    logic         i_valid;
    logic         i_inverse;
    logic         o_ready;
    logic [127:0] o_data;
    logic         o_valid;
    logic         i_ready;

    int checks = 0;
    int errors = 0;

    mix_columns_seq #(.COLS_PER_CYCLE(COLS_PER_CYCLE)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .i_inverse (i_inverse),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Carry-less polynomial product reduced modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    // Circulant matrix product on one column
    function automatic logic [31:0] model_col(input logic [31:0] col, input logic inv);
        logic [7:0]  a [4];
        logic [7:0]  coef [4];
        logic [7:0]  acc;
        logic [31:0] res;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < 4; i++) a[i] = col[31 - 8*i -: 8];
        res = '0;
        for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[j], a[(r + j) % 4]);
            res[31 - 8*r -: 8] = acc;
        end
        return res;
    endfunction

    function automatic logic [127:0] model_state(input logic [127:0] s, input logic inv);
        logic [127:0] res;
        logic eff;
`ifdef MIX_INV_EN
        eff = inv;
`else
        eff = 1'b0;
`endif
        for (int c = 0; c < 4; c++) res[127 - 32*c -: 32] = model_col(s[127 - 32*c -: 32], eff);
        return res;
    endfunction

    // Wait (bounded) for o_ready, offer one block, then count cycles to o_valid
    task automatic send_block(input logic [127:0] d, input logic inv, output int lat);
        int w;
        w = 0;
        while (!o_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!o_ready) check("ready_timeout", 128'(o_ready), 128'(1));
        i_data    = d;
        i_inverse = inv;
        i_valid   = 1'b1;
        @(negedge clk);
        i_valid   = 1'b0;
        i_data    = {$urandom, $urandom, $urandom, $urandom};
        i_inverse = ~inv;
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_block();
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    initial begin
        int           lat;
        logic [127:0] exp_d;
        logic [127:0] rnd;
        logic [127:0] exp_q [$];
        logic         accepted;
        int           sent;
        int           recv;
        int           cyc;

        n_rst = 1'b0; i_data = '0; i_valid = 1'b0; i_inverse = 1'b0; i_ready = 1'b0;
        #12;
        check("reset_ready", 128'(o_ready), 128'(1));
        check("reset_valid", 128'(o_valid), 128'(0));
        check("reset_data", o_data, '0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // FIPS-197 forward vector
        send_block(FIPS_IN, 1'b0, lat);
        check("fips_latency", 128'(lat), 128'(N));
        check("fips_data", o_data, FIPS_OUT);
        release_block();

        // Column vectors packed as one state
        send_block(COLV_IN, 1'b0, lat);
        check("colvec_latency", 128'(lat), 128'(N));
        check("colvec_data", o_data, COLV_OUT);
        release_block();

        // Inverse request
        send_block(FIPS_OUT, 1'b1, lat);
        check("inv_latency", 128'(lat), 128'(N));
`ifdef MIX_INV_EN
        check("inv_data", o_data, FIPS_IN);
`else
        check("inv_ignored_data", o_data, model_state(FIPS_OUT, 1'b0));
`endif
        release_block();

        // Backpressure in DONE with a competing i_valid
        rnd = {$urandom, $urandom, $urandom, $urandom};
        exp_d = model_state(rnd, 1'b0);
        send_block(rnd, 1'b0, lat);
        check("bp_latency", 128'(lat), 128'(N));
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1;
            i_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("bp_valid", 128'(o_valid), 128'(1));
            check("bp_data", o_data, exp_d);
            check("bp_ready", 128'(o_ready), 128'(0));
        end
        i_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 128'(o_ready), 128'(1));
        check("bp_release_valid", 128'(o_valid), 128'(0));
        check("bp_no_accept_data", o_data, exp_d);
        i_valid = 1'b0;
        i_ready = 1'b0;
        @(negedge clk);

        // Reset after one BUSY cycle
        i_data = {$urandom, $urandom, $urandom, $urandom};
        i_inverse = 1'b0;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("midrst_valid", 128'(o_valid), 128'(0));
        check("midrst_data", o_data, '0);
        check("midrst_ready", 128'(o_ready), 128'(1));
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        send_block('0, 1'b0, lat);
        check("post_rst_latency", 128'(lat), 128'(N));
        check("post_rst_data", o_data, '0);
        release_block();

        // Randomized streaming against the model
        sent = 0; recv = 0; cyc = 0; accepted = 1'b0;
        i_valid = 1'b0;
        while (recv < 500 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (accepted) i_valid = 1'b0;
            if (!i_valid && sent < 500 && $urandom_range(3) != 0) begin
                i_data    = {$urandom, $urandom, $urandom, $urandom};
                i_inverse = 1'($urandom_range(1));
                i_valid   = 1'b1;
            end
            i_ready = ($urandom_range(2) != 0);
            accepted = 1'b0;
            if (i_valid && o_ready) begin
                exp_q.push_back(model_state(i_data, i_inverse));
                sent++;
                accepted = 1'b1;
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra_block", 128'(o_valid), 128'(0));
                end else begin
                    check("stream_data", o_data, exp_q.pop_front());
                end
                recv++;
            end
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("stream_recv_count", 128'(recv), 128'(500));
        check("stream_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
